// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: reads opcode + 0/1/2 operand bytes and strobes the address-control stage.
// Optional FETCH_TIMEOUT_EN adds a per-byte wait counter that aborts a stalled fetch and raises fault.
module fetch_sequencer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       mem_ready,
    input  logic [7:0] mem_data,
    output logic       mem_rd,
    output logic       PC_inc,
    output logic       PC_load,
    output logic       AR_load,
    output logic       TL_load,
    output logic       TH_load,
    output logic       sel,
    output logic [7:0] opcode,
    output logic [7:0] imm,
    output logic       instr_valid,
    output logic       busy,
    output logic       fault
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH_OP, S_FETCH_LO, S_FETCH_HI, S_COMMIT, S_DONE
    } state_t;

    state_t     r_state, w_next;
    logic [7:0] r_opcode, r_imm;
    logic [1:0] w_cls;
    logic       w_fetch, w_timeout;

    assign w_cls   = r_opcode[7:6];
    assign w_fetch = (r_state == S_FETCH_OP) || (r_state == S_FETCH_LO) ||
                     (r_state == S_FETCH_HI);

`ifdef FETCH_TIMEOUT_EN
    logic [15:0] r_wait;
    logic        r_fault;

    // Fires on the TIMEOUT_CYCLES-th consecutive wait cycle of one byte.
    assign w_timeout = w_fetch && !mem_ready && (r_wait == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait  <= '0;
            r_fault <= 1'b0;
        end else begin
            if (w_fetch && !mem_ready && !w_timeout) r_wait <= r_wait + 16'd1;
            else                                     r_wait <= '0;
            if (w_timeout)                           r_fault <= 1'b1;
            else if (r_state == S_IDLE && start)     r_fault <= 1'b0;
        end
    end

    assign fault = r_fault;
`else
    logic w_unused_tmo;
    assign w_timeout    = 1'b0;
    assign fault        = 1'b0;
    assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_opcode <= 8'h00;
            r_imm    <= 8'h00;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH_OP && mem_ready) r_opcode <= mem_data;
            if (r_state == S_FETCH_LO && mem_ready && w_cls == 2'b11) r_imm <= mem_data;
        end
    end

    // Strobes are gated by rst so a reset cycle never issues a partial update downstream.
    always_comb begin
        w_next      = r_state;
        mem_rd      = w_fetch;
        busy        = (r_state != S_IDLE);
        PC_inc      = 1'b0;
        PC_load     = 1'b0;
        AR_load     = 1'b0;
        TL_load     = 1'b0;
        TH_load     = 1'b0;
        sel         = 1'b1;
        instr_valid = 1'b0;
        case (r_state)
            S_IDLE: if (start) w_next = S_FETCH_OP;
            S_FETCH_OP: if (mem_ready) begin
                PC_inc = !rst;
                w_next = (mem_data[7:6] == 2'b00) ? S_DONE : S_FETCH_LO;
            end
            S_FETCH_LO: if (mem_ready) begin
                PC_inc  = !rst;
                TL_load = !rst && (w_cls != 2'b11);
                w_next  = (w_cls == 2'b11) ? S_DONE : S_FETCH_HI;
            end
            S_FETCH_HI: if (mem_ready) begin
                PC_inc  = !rst;
                TH_load = !rst;
                w_next  = S_COMMIT;
            end
            S_COMMIT: begin
                sel     = rst;
                AR_load = !rst && (w_cls == 2'b01);
                PC_load = !rst && (w_cls == 2'b10);
                w_next  = S_DONE;
            end
            S_DONE: begin
                instr_valid = !rst;
                w_next      = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (w_timeout) w_next = S_IDLE;
    end

    assign opcode = r_opcode;
    assign imm    = r_imm;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer: a byte memory, a downstream PC/AR/temp model, and a
// per-instruction phase model (fetch N bytes, optional commit, done) giving expected strobes.
module tb_fetch_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, mem_ready;
    logic [7:0] mem_data;
    logic       mem_rd, PC_inc, PC_load, AR_load, TL_load, TH_load, sel, instr_valid, busy, fault;
    logic [7:0] opcode, imm;

    fetch_sequencer #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .mem_ready(mem_ready), .mem_data(mem_data),
        .mem_rd(mem_rd), .PC_inc(PC_inc), .PC_load(PC_load), .AR_load(AR_load),
        .TL_load(TL_load), .TH_load(TH_load), .sel(sel), .opcode(opcode), .imm(imm),
        .instr_valid(instr_valid), .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [256];
    logic [15:0] dpc, ar_q;
    logic [7:0]  tl_q, th_q, m_imm;
    int          n_chk, n_pass;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // One clock cycle; obs = {busy,mem_rd,PC_inc,PC_load,AR_load,TL_load,TH_load,sel,instr_valid}
    task automatic step(input bit s, input bit rdy, input bit r, output logic [8:0] obs);
        @(negedge clk);
        start = s; mem_ready = rdy; rst = r; mem_data = mem[dpc[7:0]];
        #1;
        obs = {busy, mem_rd, PC_inc, PC_load, AR_load, TL_load, TH_load, sel, instr_valid};
        if (AR_load) ar_q = {th_q, tl_q};
        if (PC_load) dpc = {th_q, tl_q};
        else if (PC_inc) dpc = dpc + 16'd1;
        if (TL_load) tl_q = mem_data;
        if (TH_load) th_q = mem_data;
    endtask

    task automatic put3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        logic [7:0] a;
        a = dpc[7:0];
        mem[a] = b0; a = a + 8'd1; mem[a] = b1; a = a + 8'd1; mem[a] = b2;
    endtask

    // wmode: 0 zero-wait, 1 random waits (at most 2 in a row), 2 three waits on the low operand
    task automatic fetch_one(input int wmode);
        logic [15:0] a0, exp_pc, exp_ar;
        logic [7:0]  op, lo, hi, ia;
        logic [8:0]  obs, exp;
        int cls, need, acc, waits, cw, low_w, done_k, base;
        bit cdone, fin, fetch, commit, done, rdy;
        a0 = dpc; ia = a0[7:0];
        op = mem[ia]; ia = ia + 8'd1; lo = mem[ia]; ia = ia + 8'd1; hi = mem[ia];
        cls  = int'(op[7:6]);
        need = (cls == 0) ? 1 : (cls == 3) ? 2 : 3;
        base = (cls == 0) ? 2 : (cls == 3) ? 3 : 5;
        exp_pc = (cls == 2) ? {hi, lo} : a0 + 16'(need);
        exp_ar = (cls == 1) ? {hi, lo} : ar_q;
        if (cls == 3) m_imm = lo;
        acc = 0; waits = 0; cw = 0; low_w = 0; done_k = -1; cdone = 0; fin = 0;
        step(1'b1, 1'b0, 1'b0, obs);
        chk("idle_start", 32'(obs), 32'(9'b000000010));
        for (int k = 1; k < 100 && !fin; k++) begin
            fetch  = (acc < need);
            commit = !fetch && (cls == 1 || cls == 2) && !cdone;
            done   = !fetch && !commit;
            if (!fetch)           rdy = 1'($urandom_range(0, 1));
            else if (wmode == 0)  rdy = 1'b1;
            else if (wmode == 2)  rdy = !(acc == 1 && low_w < 3);
            else                  rdy = (cw >= 2) || ($urandom_range(0, 2) != 0);
            exp = {1'b1, fetch, fetch && rdy, commit && cls == 2, commit && cls == 1,
                   fetch && rdy && acc == 1 && (cls == 1 || cls == 2),
                   fetch && rdy && acc == 2, !commit, done};
            step(1'($urandom_range(0, 1)), rdy, 1'b0, obs);
            chk("strobes", 32'(obs), 32'(exp));
            if (fetch) begin
                if (rdy) begin acc++; cw = 0; end
                else begin waits++; cw++; if (acc == 1) low_w++; end
            end
            if (commit) cdone = 1;
            if (done) begin done_k = k; fin = 1; end
        end
        step(1'b0, 1'b0, 1'b0, obs);
        chk("idle_after", 32'(obs), 32'(9'b000000010));
        chk("latency", 32'(done_k), 32'(base + waits));
        chk("opcode", 32'(opcode), 32'(op));
        chk("imm", 32'(imm), 32'(m_imm));
        chk("pc", 32'(dpc), 32'(exp_pc));
        chk("ar", 32'(ar_q), 32'(exp_ar));
        chk("fault", 32'(fault), 32'd0);
    endtask

    initial begin
        logic [8:0]  obs;
        logic [15:0] ar_before;
        bit          iv_seen;
        n_chk = 0; n_pass = 0;
        rst = 1'b1; start = 1'b0; mem_ready = 1'b0; mem_data = 8'h00;
        dpc = 16'h0000; ar_q = 16'h0000; tl_q = 8'h00; th_q = 8'h00; m_imm = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

        step(1'b0, 1'b0, 1'b1, obs);
        step(1'b0, 1'b1, 1'b1, obs);
        step(1'b0, 1'b0, 1'b0, obs);
        chk("reset_strobes", 32'(obs), 32'(9'b000000010));
        chk("reset_opcode", 32'(opcode), 32'h00);
        chk("reset_imm", 32'(imm), 32'h00);
        chk("reset_fault", 32'(fault), 32'd0);

        put3(8'h05, 8'h00, 8'h00); fetch_one(0);
        put3(8'h4A, 8'h34, 8'h12); fetch_one(0);
        chk("ar_1234", 32'(ar_q), 32'h1234);
        put3(8'h80, 8'hCD, 8'hAB); fetch_one(0);
        chk("pc_abcd", 32'(dpc), 32'hABCD);
        put3(8'hC1, 8'h7F, 8'h00); fetch_one(0);
        chk("imm_7f", 32'(imm), 32'h7F);
        put3(8'h4A, 8'h9C, 8'h5E); fetch_one(2);

        // Reset while the high operand byte is being accepted
        put3(8'h4A, 8'h56, 8'h78);
        ar_before = ar_q;
        step(1'b1, 1'b0, 1'b0, obs);
        step(1'b0, 1'b1, 1'b0, obs);
        step(1'b0, 1'b1, 1'b0, obs);
        step(1'b0, 1'b1, 1'b1, obs);
        chk("rst_no_strobe", 32'(obs[6:2]), 32'd0);
        step(1'b0, 1'b1, 1'b0, obs);
        chk("rst_idle", 32'({obs[8], obs[4], obs[0]}), 32'd0);
        chk("rst_opcode", 32'(opcode), 32'h00);
        chk("rst_ar_kept", 32'(ar_q), 32'(ar_before));
        m_imm = 8'h00;

`ifdef FETCH_TIMEOUT_EN
        iv_seen = 0;
        step(1'b1, 1'b0, 1'b0, obs);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0, obs);
            iv_seen |= obs[0];
            chk("tmo_wait_rd", 32'(obs[7]), 32'd1);
        end
        step(1'b0, 1'b0, 1'b0, obs);
        chk("tmo_idle", 32'(obs[8]), 32'd0);
        chk("tmo_fault", 32'(fault), 32'd1);
        chk("tmo_no_valid", 32'(iv_seen), 32'd0);
        put3(8'h05, 8'h00, 8'h00); fetch_one(0);
`else
        iv_seen = 0;
        chk("no_tmo_fault", 32'(fault | iv_seen), 32'd0);
`endif

        for (int n = 0; n < 60; n++) begin
            put3(8'($urandom), 8'($urandom), 8'($urandom));
            fetch_one(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
